memory_arbitration: RTL and testbench
=====================================

MEMORY_ARBITRATION -- requirements
Module: memory_arbitration

Interface
REQ-001 SHALL have port clock, input, 1 bit: single clock, all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port moduleEnable, input, 1 bit: 1 allows new grants; 0 blocks new grants.
REQ-004 SHALL have ports memoryEnable1 and memoryEnable2, inputs, 1 bit each: per-requester access request, held high until that requester's done.
REQ-005 SHALL have ports readWrite1 and readWrite2, inputs, 1 bit each: 1 = read, 0 = write.
REQ-006 SHALL have ports Address1 and Address2, inputs, 15 bits each: word address.
REQ-007 SHALL have ports Data1 and Data2, inputs, 32 bits each: write data.
REQ-008 SHALL have ports DataOut1 and DataOut2, outputs, 32 bits each: registered read data for each requester.
REQ-009 SHALL have ports done1 and done2, outputs, 1 bit each: registered one-cycle completion pulse per requester.

Function
REQ-010 SHALL contain an internal 32768 x 32-bit single-port synchronous memory, initialised to all zeros at configuration.
REQ-011 SHALL use an FSM with states IDLE, ACCESS and RESPOND.
REQ-012 In IDLE with moduleEnable=1 and at least one memoryEnable high at edge k, SHALL grant one requester, latch its address/data/readWrite, and enter ACCESS.
REQ-013 In ACCESS at edge k+1, SHALL perform one memory operation (write Data to Address, or read Address), then enter RESPOND.
REQ-014 In RESPOND at edge k+2, SHALL:
- load the read word into the granted DataOut (reads only);
- set the granted done to 1 and return to IDLE.
REQ-015 done SHALL be high for exactly one cycle, and only on the granted port; the other port's done and DataOut SHALL be unaffected.
REQ-016 A write SHALL NOT change DataOut; DataOut SHALL hold its last value until the next read completes on that port.
REQ-017 Fixed latency: request sampled in IDLE -> done high 2 cycles later; minimum spacing between grants is 3 cycles.
REQ-018 Arbitration SHALL be round-robin: when both request in IDLE, grant the port not served last.
REQ-019 With a single requester, that requester SHALL be granted.
REQ-020 Latched address/data/readWrite SHALL be used throughout a transaction; input changes after the grant SHALL have no effect.
REQ-021 moduleEnable=0 SHALL block grants in IDLE only; an in-flight transaction SHALL complete normally.
REQ-022 memoryEnable still high in IDLE after a done SHALL be treated as a new request.
REQ-023 A requester dropping memoryEnable after being granted SHALL NOT abort the transaction.
REQ-024 Read-after-write to the same address by either port SHALL return the written value.

Reset
REQ-025 reset=0 SHALL immediately force:
- state = IDLE;
- done1 = done2 = 0;
- DataOut1 = DataOut2 = 32'h0;
- round-robin pointer set so port 1 wins the first tie.
REQ-026 Reset SHALL NOT clear memory contents.
REQ-027 An in-flight transaction aborted by reset SHALL be discarded without asserting done; an interrupted write may or may not have reached memory.
REQ-028 After reset deasserts, the first grant SHALL occur no earlier than the first rising edge with reset=1.

Verification
REQ-029 Post-configuration read: reset pulse, port 1 read at Address 15'h0000 -> done1 pulses 2 cycles after sampling, DataOut1 = 32'h00000000.
REQ-030 Write then read: port 1 writes 32'hDEADBEEF to 15'h0005, then port 2 reads 15'h0005 -> done1 pulses and DataOut1 is unchanged; DataOut2 = 32'hDEADBEEF with done2.
REQ-031 Tie: both ports request reads in the same cycle right after reset -> port 1 is served first (done1), then port 2 (done2) 3 cycles later. A second simultaneous pair is served port 2 first if port 1 was last served.
REQ-032 moduleEnable=0 while memoryEnable1=1 -> no done for any number of cycles. Raising moduleEnable -> done1 is high 2 cycles after the first edge on which moduleEnable=1 is sampled.
REQ-033 Reset asserted during ACCESS -> done stays 0, outputs are 0, and the FSM is in IDLE. A subsequent request completes normally.
REQ-034 Address 15'h7FFF write/read (upper boundary) -> data round-trips with no aliasing onto 15'h0000.

Source files
------------

// File: rtl/memory_arbitration.sv
// Two-port round-robin arbiter in front of a 32K x 32 single-port synchronous RAM.
// Each grant runs IDLE -> ACCESS -> RESPOND, so done pulses two edges after the grant.
module memory_arbitration (
  input  logic        clock,
  input  logic        reset,
  input  logic        moduleEnable,
  input  logic        memoryEnable1,
  input  logic        memoryEnable2,
  input  logic        readWrite1,
  input  logic        readWrite2,
  input  logic [14:0] Address1,
  input  logic [14:0] Address2,
  input  logic [31:0] Data1,
  input  logic [31:0] Data2,
  output logic [31:0] DataOut1,
  output logic [31:0] DataOut2,
  output logic        done1,
  output logic        done2
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t      state_r;
  logic        gnt2_r;
  logic        last2_r;
  logic        rw_r;
  logic [14:0] addr_r;
  logic [31:0] wdata_r;
  logic [31:0] rdata_r;
  logic [31:0] mem_r [0:32767];

  logic        req_s;
  logic        pick2_s;

  // Requester selection: on a tie the port not served last wins.
  always_comb begin
    req_s   = moduleEnable & (memoryEnable1 | memoryEnable2);
    pick2_s = 1'b0;
    if (memoryEnable1 && memoryEnable2) begin
      pick2_s = ~last2_r;
    end else if (memoryEnable2) begin
      pick2_s = 1'b1;
    end else begin
      pick2_s = 1'b0;
    end
  end

  // Transaction sequencer with registered done and read-data outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      gnt2_r   <= 1'b0;
      last2_r  <= 1'b1;
      rw_r     <= 1'b0;
      addr_r   <= 15'h0000;
      wdata_r  <= 32'h0000_0000;
      done1    <= 1'b0;
      done2    <= 1'b0;
      DataOut1 <= 32'h0000_0000;
      DataOut2 <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          done1 <= 1'b0;
          done2 <= 1'b0;
          if (req_s) begin
            gnt2_r  <= pick2_s;
            last2_r <= pick2_s;
            rw_r    <= pick2_s ? readWrite2 : readWrite1;
            addr_r  <= pick2_s ? Address2   : Address1;
            wdata_r <= pick2_s ? Data2      : Data1;
            state_r <= ACCESS;
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          state_r <= RESPOND;
        end
        RESPOND: begin
          if (gnt2_r) begin
            done2 <= 1'b1;
            if (rw_r) begin
              DataOut2 <= rdata_r;
            end else begin
              DataOut2 <= DataOut2;
            end
          end else begin
            done1 <= 1'b1;
            if (rw_r) begin
              DataOut1 <= rdata_r;
            end else begin
              DataOut1 <= DataOut1;
            end
          end
          state_r <= IDLE;
        end
        default: begin
          done1   <= 1'b0;
          done2   <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // RAM port: contents survive reset, so this block has no reset term.
  always_ff @(posedge clock) begin
    if (state_r == ACCESS) begin
      if (rw_r) begin
        rdata_r <= mem_r[addr_r];
      end else begin
        mem_r[addr_r] <= wdata_r;
      end
    end
  end

endmodule

// File: tb/tb_memory_arbitration.sv
// Randomized bench for memory_arbitration: a transaction-level model fills a scoreboard
// of expected completions that an independent monitor checks against done/DataOut.
`timescale 1ns/1ps
module tb_memory_arbitration;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        moduleEnable = 1'b0;
  logic        memoryEnable1 = 1'b0;
  logic        memoryEnable2 = 1'b0;
  logic        readWrite1 = 1'b0;
  logic        readWrite2 = 1'b0;
  logic [14:0] Address1 = 15'h0000;
  logic [14:0] Address2 = 15'h0000;
  logic [31:0] Data1 = 32'h0;
  logic [31:0] Data2 = 32'h0;
  logic [31:0] DataOut1;
  logic [31:0] DataOut2;
  logic        done1;
  logic        done2;

  memory_arbitration dut (
    .clock(clock), .reset(reset), .moduleEnable(moduleEnable),
    .memoryEnable1(memoryEnable1), .memoryEnable2(memoryEnable2),
    .readWrite1(readWrite1), .readWrite2(readWrite2),
    .Address1(Address1), .Address2(Address2), .Data1(Data1), .Data2(Data2),
    .DataOut1(DataOut1), .DataOut2(DataOut2), .done1(done1), .done2(done2)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          port;
    int          cyc;
    logic [31:0] d1;
    logic [31:0] d2;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_m [int];
  int          last_served = 2;
  logic [31:0] m_d1 = 32'h0, m_d2 = 32'h0;
  logic [31:0] cur_d1 = 32'h0, cur_d2 = 32'h0;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [31:0] mem_rd(input int a);
    return mem_m.exists(a) ? mem_m[a] : 32'h0;
  endfunction

  function automatic logic [14:0] rand_addr();
    int unsigned x;
    x = $urandom;
    case ($urandom_range(0, 5))
      0: return 15'h0000;
      1: return 15'h7FFF;
      2: return 15'h0005;
      3: return 15'h7FFE;
      4: return {12'h000, x[2:0]};
      default: return x[14:0];
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_d1 = 32'h0; m_d2 = 32'h0;
    cur_d1 = 32'h0; cur_d2 = 32'h0;
    last_served = 2;
  endtask

  // Apply one transaction to the model and record its completion.
  task automatic predict(input int p, input logic rw, input logic [14:0] a,
                         input logic [31:0] d, input int at);
    exp_t e;
    if (rw) begin
      if (p == 1) m_d1 = mem_rd(int'(a));
      else        m_d2 = mem_rd(int'(a));
    end else begin
      mem_m[int'(a)] = d;
    end
    last_served = p;
    e.port = p; e.cyc = at; e.d1 = m_d1; e.d2 = m_d2;
    sb.push_back(e);
  endtask

  // Called just before the grant edge; returns at the negedge where done is visible.
  task automatic serve(input int p, input bit wiggle);
    @(negedge clock);
    if (wiggle) begin
      if (p == 1) begin
        Address1 = rand_addr(); Data1 = $urandom; readWrite1 = ($urandom_range(0, 1) == 1);
        if ($urandom_range(0, 1) == 1) memoryEnable1 = 1'b0;
      end else begin
        Address2 = rand_addr(); Data2 = $urandom; readWrite2 = ($urandom_range(0, 1) == 1);
        if ($urandom_range(0, 1) == 1) memoryEnable2 = 1'b0;
      end
      if ($urandom_range(0, 1) == 1) moduleEnable = 1'b0;
    end
    @(negedge clock);
    @(negedge clock);
    if (p == 1) memoryEnable1 = 1'b0;
    else        memoryEnable2 = 1'b0;
    moduleEnable = 1'b1;
  endtask

  task automatic episode(input bit r1, input bit r2, input bit rw1, input bit rw2,
                         input logic [14:0] a1, input logic [14:0] a2,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input int hold, input bit gap, input bit wiggle);
    int k, f, s;
    if (gap) @(negedge clock);
    readWrite1 = rw1; readWrite2 = rw2;
    Address1 = a1; Address2 = a2; Data1 = d1; Data2 = d2;
    memoryEnable1 = r1; memoryEnable2 = r2;
    moduleEnable = (hold == 0);
    for (int i = 0; i < hold; i++) @(negedge clock);
    moduleEnable = 1'b1;
    k = cyc + 1;
    if (r1 && r2) f = (last_served == 1) ? 2 : 1;
    else          f = r1 ? 1 : 2;
    s = (r1 && r2) ? 3 - f : 0;
    if (f == 1) predict(1, rw1, a1, d1, k + 2);
    else        predict(2, rw2, a2, d2, k + 2);
    if (s == 1) predict(1, rw1, a1, d1, k + 5);
    if (s == 2) predict(2, rw2, a2, d2, k + 5);
    serve(f, wiggle);
    if (s != 0) serve(s, wiggle);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    memoryEnable1 = 1'b0; memoryEnable2 = 1'b0; moduleEnable = 1'b0;
    model_reset();
    #1;
    check("reset_done1", {31'h0, done1}, 32'h0);
    check("reset_done2", {31'h0, done2}, 32'h0);
    check("reset_dout1", DataOut1, 32'h0);
    check("reset_dout2", DataOut2, 32'h0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // Monitor: every done must match the scoreboard head in port and cycle.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (reset) begin
      if (sb.size() > 0 && cyc > sb[0].cyc) begin
        vectors++; miscompares++;
        $display("FAIL done_missing: port %0d saw no done, required at cycle %0d (now %0d)",
                 sb[0].port, sb[0].cyc, cyc);
        e = sb.pop_front();
        cur_d1 = e.d1; cur_d2 = e.d2;
      end
      if (done1 || done2) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_done: done1=%0b done2=%0b at cycle %0d, required none",
                   done1, done2, cyc);
        end else begin
          e = sb.pop_front();
          if (done1 !== (e.port == 1) || done2 !== (e.port == 2) || cyc != e.cyc) begin
            miscompares++;
            $display("FAIL done_event: done1=%0b done2=%0b at cycle %0d, required port %0d at cycle %0d",
                     done1, done2, cyc, e.port, e.cyc);
          end
          cur_d1 = e.d1; cur_d2 = e.d2;
        end
      end
      check("dataout1", DataOut1, cur_d1);
      check("dataout2", DataOut2, cur_d2);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bit r1, r2;
    int r;
    #2 reset = 1'b0;
    #1;
    check("por_done1", {31'h0, done1}, 32'h0);
    check("por_done2", {31'h0, done2}, 32'h0);
    check("por_dout1", DataOut1, 32'h0);
    check("por_dout2", DataOut2, 32'h0);
    memoryEnable1 = 1'b1; readWrite1 = 1'b1; moduleEnable = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("held_reset_done1", {31'h0, done1}, 32'h0);
      check("held_reset_done2", {31'h0, done2}, 32'h0);
    end
    reset = 1'b1;
    // Post-configuration read of address 0.
    episode(1, 0, 1, 0, 15'h0000, 15'h0000, 32'h0, 32'h0, 0, 0, 0);
    // Write by port 1, read back by port 2.
    episode(1, 0, 0, 0, 15'h0005, 15'h0000, 32'hDEADBEEF, 32'h0, 0, 1, 0);
    episode(0, 1, 0, 1, 15'h0000, 15'h0005, 32'h0, 32'h0, 0, 1, 0);
    // Ties after reset, then port 1 alone, then a tie that port 2 must win.
    do_reset();
    episode(1, 1, 1, 1, 15'h0005, 15'h0005, 32'h0, 32'h0, 0, 0, 0);
    episode(1, 0, 1, 0, 15'h0000, 15'h0000, 32'h0, 32'h0, 0, 1, 0);
    episode(1, 1, 1, 1, 15'h0005, 15'h0005, 32'h0, 32'h0, 0, 1, 0);
    // Request held while moduleEnable is low.
    episode(1, 0, 1, 0, 15'h0005, 15'h0000, 32'h0, 32'h0, 6, 1, 0);
    // Reset while a read by port 2 is in ACCESS.
    @(negedge clock);
    memoryEnable2 = 1'b1; readWrite2 = 1'b1; Address2 = 15'h0005; moduleEnable = 1'b1;
    @(posedge clock);
    #2 reset = 1'b0;
    memoryEnable2 = 1'b0;
    model_reset();
    #1;
    check("abort_done1", {31'h0, done1}, 32'h0);
    check("abort_done2", {31'h0, done2}, 32'h0);
    check("abort_dout1", DataOut1, 32'h0);
    check("abort_dout2", DataOut2, 32'h0);
    repeat (2) begin
      @(negedge clock);
      check("abort_hold_done2", {31'h0, done2}, 32'h0);
    end
    reset = 1'b1;
    // Memory survives reset; then the upper address boundary.
    episode(0, 1, 0, 1, 15'h0000, 15'h0005, 32'h0, 32'h0, 0, 0, 0);
    episode(1, 0, 0, 0, 15'h0000, 15'h0000, 32'h12345678, 32'h0, 0, 1, 0);
    episode(0, 1, 0, 0, 15'h0000, 15'h7FFF, 32'h0, 32'hA5A55A5A, 0, 1, 0);
    episode(1, 0, 1, 0, 15'h0000, 15'h0000, 32'h0, 32'h0, 0, 0, 0);
    episode(1, 1, 1, 1, 15'h7FFF, 15'h0000, 32'h0, 32'h0, 0, 1, 0);
    // Randomized traffic.
    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(1, 3);
      r1 = (r != 2);
      r2 = (r != 1);
      if ($urandom_range(0, 39) == 0) do_reset();
      episode(r1, r2, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
              rand_addr(), rand_addr(), $urandom, $urandom,
              ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0,
              ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
    end
    repeat (6) @(negedge clock);
    check("scoreboard_drained", sb.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
